// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame width, mode encodings and slave FSM states.
package spi_pkg;

   localparam int SPI_DATA_W = 16;

   localparam logic [1:0] SPI_MODE0 = 2'd0;
   localparam logic [1:0] SPI_MODE1 = 2'd1;
   localparam logic [1:0] SPI_MODE2 = 2'd2;
   localparam logic [1:0] SPI_MODE3 = 2'd3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } spi_state_e;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the user-side word interface of the SPI slave endpoint.
interface spi_slave_if #(parameter int DATA_W = spi_pkg::SPI_DATA_W);
   import spi_pkg::*;

   // spi_done/spi_abort are single-cycle pulses; spi_rdata is valid with spi_done and held
   // until the next one. spi_sdata is sampled in the load cycle (CS fall or the spi_done cycle).
   logic [1:0]        spi_mode;
   logic              spi_sclk;
   logic              spi_cs_n;
   logic              spi_mosi;
   logic              spi_miso;
   logic [DATA_W-1:0] spi_sdata;
   logic [DATA_W-1:0] spi_rdata;
   logic              spi_done;
   logic              spi_busy;
   logic              spi_abort;
   spi_state_e        spi_state;

   modport slave (
      input  spi_mode, spi_sclk, spi_cs_n, spi_mosi, spi_sdata,
      output spi_miso, spi_rdata, spi_done, spi_busy, spi_abort, spi_state
   );

   modport master (
      output spi_mode, spi_sclk, spi_cs_n, spi_mosi, spi_sdata,
      input  spi_miso, spi_rdata, spi_done, spi_busy, spi_abort, spi_state
   );

endinterface

// File: rtl/spi_sync.sv
// N-stage flop synchronizer with asynchronous active-low reset to a chosen value.
module spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] chain_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         chain_q <= {STAGES{RST_VAL}};
      end else begin
         chain_q <= {chain_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversamples SCLK/CS/MOSI on sys_clk and shifts DATA_W-bit words
// MSB first in any SPI mode, delivering each word with a spi_done pulse.
module spi_slave
   import spi_pkg::*;
#(
   parameter int DATA_W      = SPI_DATA_W,
   parameter int SYNC_STAGES = 2
) (
   input logic      sys_clk,
   input logic      sys_rst_n,
   spi_slave_if.slave bus
);

   localparam int CNT_W   = $clog2(DATA_W);
   localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

   logic cs_s, sclk_s, mosi_s;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk_i(sys_clk), .rst_ni(sys_rst_n), .d_i(bus.spi_cs_n), .q_o(cs_s)
   );
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk_i(sys_clk), .rst_ni(sys_rst_n), .d_i(bus.spi_sclk), .q_o(sclk_s)
   );
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk_i(sys_clk), .rst_ni(sys_rst_n), .d_i(bus.spi_mosi), .q_o(mosi_s)
   );

   spi_state_e        state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic              cs_prev_q, cs_prev_d;
   logic              sclk_prev_q, sclk_prev_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
   logic              tx_hold_q, tx_hold_d;
   logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              done_q, done_d;
   logic              abort_q, abort_d;
   logic              reload_q, reload_d;
   logic              armed_q, armed_d;
   logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;

   logic cpol, cpha, cs_fall, cs_rise, lead_edge, trail_edge, sample_edge, drive_edge;

   // A CS already low when reset releases must not look like a fall: loads are only
   // accepted once the chain has flushed and CS has been seen high.
   assign cs_fall = armed_q & cs_prev_q & ~cs_s;
   assign cs_rise = ~cs_prev_q & cs_s;

   assign cpol        = mode_q[1];
   assign cpha        = mode_q[0];
   assign lead_edge   = (sclk_prev_q == cpol) && (sclk_s != cpol);
   assign trail_edge  = (sclk_prev_q != cpol) && (sclk_s == cpol);
   assign sample_edge = cpha ? trail_edge : lead_edge;
   assign drive_edge  = cpha ? lead_edge : trail_edge;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= ST_IDLE;
         mode_q      <= SPI_MODE0;
         cs_prev_q   <= 1'b1;
         sclk_prev_q <= 1'b0;
         bit_cnt_q   <= '0;
         tx_shift_q  <= '0;
         tx_hold_q   <= 1'b0;
         rx_shift_q  <= '0;
         rdata_q     <= '0;
         done_q      <= 1'b0;
         abort_q     <= 1'b0;
         reload_q    <= 1'b0;
         armed_q     <= 1'b0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         cs_prev_q   <= cs_prev_d;
         sclk_prev_q <= sclk_prev_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_shift_q  <= tx_shift_d;
         tx_hold_q   <= tx_hold_d;
         rx_shift_q  <= rx_shift_d;
         rdata_q     <= rdata_d;
         done_q      <= done_d;
         abort_q     <= abort_d;
         reload_q    <= reload_d;
         armed_q     <= armed_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      cs_prev_d   = cs_s;
      sclk_prev_d = sclk_s;
      bit_cnt_d   = bit_cnt_q;
      tx_shift_d  = tx_shift_q;
      tx_hold_d   = tx_hold_q;
      rx_shift_d  = rx_shift_q;
      rdata_d     = rdata_q;
      done_d      = 1'b0;
      abort_d     = 1'b0;
      reload_d    = 1'b0;
      armed_d     = armed_q;
      flush_cnt_d = flush_cnt_q;

      if (flush_cnt_q != FLUSH_W'(SYNC_STAGES)) begin
         flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
      end else if (cs_s) begin
         armed_d = 1'b1;
      end

      // The next word is fetched one cycle after completion so user logic can
      // update spi_sdata in the spi_done cycle itself.
      if (reload_q) begin
         tx_shift_d = bus.spi_sdata;
      end

      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d    = ST_SHIFT;
               mode_d     = bus.spi_mode;
               tx_shift_d = bus.spi_sdata;
               bit_cnt_d  = '0;
               tx_hold_d  = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (cs_rise) begin
               state_d   = ST_IDLE;
               abort_d   = (bit_cnt_q != '0);
               bit_cnt_d = '0;
            end else if (sample_edge) begin
               rx_shift_d = {rx_shift_q[DATA_W-3:0], mosi_s};
               if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                  rdata_d   = {rx_shift_q, mosi_s};
                  done_d    = 1'b1;
                  bit_cnt_d = '0;
                  tx_hold_d = 1'b1;
                  reload_d  = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  if (!cpha) begin
                     tx_hold_d = 1'b0;
                  end
               end
            end else if (drive_edge) begin
               if (tx_hold_q) begin
                  if (cpha) begin
                     tx_hold_d = 1'b0;
                  end
               end else begin
                  tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.spi_miso  = (state_q == ST_SHIFT) ? tx_shift_q[DATA_W-1] : 1'b0;
   assign bus.spi_rdata = rdata_q;
   assign bus.spi_done  = done_q;
   assign bus.spi_busy  = (state_q == ST_SHIFT);
   assign bus.spi_abort = abort_q;
   assign bus.spi_state = state_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a task-based SPI master with a spi_done-driven scoreboard.
module tb_spi_slave;
   import spi_pkg::*;

   logic sys_clk = 1'b0;
   logic sys_rst_n = 1'b0;

   spi_slave_if #(.DATA_W(SPI_DATA_W)) bus ();

   spi_slave #(.DATA_W(SPI_DATA_W), .SYNC_STAGES(2)) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .bus      (bus)
   );

   always #10 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   logic [15:0] exp_q[$];
   int pass_cnt = 0;
   int total_cnt = 0;
   int done_cnt = 0;
   int abort_cyc_cnt = 0;
   int done_cyc = 0;
   int last_sample_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s actual=%h expected=%h", name, act, exp);
   endtask

   // Monitor: every spi_done cycle pops one expected word.
   initial begin : monitor
      logic [15:0] e;
      forever begin
         @(negedge sys_clk);
         if (sys_rst_n) begin
            if (bus.spi_done) begin
               done_cnt++;
               done_cyc = cyc;
               if (exp_q.size() == 0) begin
                  total_cnt++;
                  $display("FAIL rdata_unexpected_done actual=%h expected=none", bus.spi_rdata);
               end else begin
                  e = exp_q.pop_front();
                  check("rdata", {16'h0, bus.spi_rdata}, {16'h0, e});
               end
            end
            if (bus.spi_abort) abort_cyc_cnt++;
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic set_mode(input logic [1:0] m);
      bus.spi_mode = m;
      bus.spi_sclk = m[1];
      wait_cyc(6);
   endtask

   task automatic cs_fall();
      bus.spi_cs_n = 1'b0;
      wait_cyc(5);
   endtask

   task automatic cs_rise();
      wait_cyc(5);
      bus.spi_cs_n = 1'b1;
      wait_cyc(8);
   endtask

   task automatic shift_word(input logic [1:0] m, input logic [15:0] tx, input int nbits,
                             input int h, output logic [15:0] rx);
      rx = '0;
      for (int i = 0; i < nbits; i++) begin
         if (!m[0]) begin
            bus.spi_mosi = tx[15-i];
            wait_cyc(h);
            rx = {rx[14:0], bus.spi_miso};
            last_sample_cyc = cyc;
            bus.spi_sclk = ~m[1];
            wait_cyc(h);
            bus.spi_sclk = m[1];
         end else begin
            wait_cyc(h);
            bus.spi_sclk = ~m[1];
            bus.spi_mosi = tx[15-i];
            wait_cyc(h);
            rx = {rx[14:0], bus.spi_miso};
            last_sample_cyc = cyc;
            bus.spi_sclk = m[1];
         end
      end
   endtask

   initial begin : stimulus
      logic [15:0] rx, rx2;
      int d0, a0;
      bus.spi_mode  = SPI_MODE0;
      bus.spi_sclk  = 1'b0;
      bus.spi_cs_n  = 1'b1;
      bus.spi_mosi  = 1'b0;
      bus.spi_sdata = '0;
      sys_rst_n = 1'b0;
      wait_cyc(3);
      sys_rst_n = 1'b1;
      wait_cyc(4);
      check("rst_miso",  {31'h0, bus.spi_miso},  32'h0);
      check("rst_rdata", {16'h0, bus.spi_rdata}, 32'h0);
      check("rst_done",  {31'h0, bus.spi_done},  32'h0);
      check("rst_busy",  {31'h0, bus.spi_busy},  32'h0);
      check("rst_abort", {31'h0, bus.spi_abort}, 32'h0);
      check("rst_state", {31'h0, bus.spi_state}, {31'h0, ST_IDLE});

      // Mode 3 single word.
      set_mode(SPI_MODE3);
      bus.spi_sdata = 16'h1234;
      exp_q.push_back(16'haaab);
      d0 = done_cnt;
      cs_fall();
      shift_word(SPI_MODE3, 16'haaab, 16, 5, rx);
      cs_rise();
      check("m3_miso_word", {16'h0, rx}, 32'h1234);
      check("m3_done_count", done_cnt - d0, 1);

      // Same pattern in all four modes.
      for (int m = 0; m < 4; m++) begin
         set_mode(2'(m));
         bus.spi_sdata = 16'h7ffe;
         exp_q.push_back(16'h8001);
         cs_fall();
         shift_word(2'(m), 16'h8001, 16, 5, rx);
         cs_rise();
         check($sformatf("mode%0d_miso_word", m), {16'h0, rx}, 32'h7ffe);
      end

      // Back-to-back words; the return word is updated in the first spi_done cycle.
      set_mode(SPI_MODE3);
      bus.spi_sdata = 16'h1111;
      exp_q.push_back(16'haaab);
      exp_q.push_back(16'h5554);
      d0 = done_cnt;
      fork
         begin
            for (int k = 0; k < 2000; k++) begin
               @(negedge sys_clk);
               if (bus.spi_done) begin
                  bus.spi_sdata = 16'hbeef;
                  break;
               end
            end
         end
      join_none
      cs_fall();
      shift_word(SPI_MODE3, 16'haaab, 16, 5, rx);
      shift_word(SPI_MODE3, 16'h5554, 16, 5, rx2);
      cs_rise();
      check("b2b_miso_word1", {16'h0, rx},  32'h1111);
      check("b2b_miso_word2", {16'h0, rx2}, 32'hbeef);
      check("b2b_done_count", done_cnt - d0, 2);

      // Abort after 7 bits.
      set_mode(SPI_MODE0);
      bus.spi_sdata = 16'h0000;
      d0 = done_cnt;
      a0 = abort_cyc_cnt;
      cs_fall();
      shift_word(SPI_MODE0, 16'hffff, 7, 5, rx);
      cs_rise();
      check("abort_pulse_cycles", abort_cyc_cnt - a0, 1);
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_rdata_kept", {16'h0, bus.spi_rdata}, 32'h5554);
      bus.spi_sdata = 16'h3c3c;
      exp_q.push_back(16'h0f0f);
      cs_fall();
      shift_word(SPI_MODE0, 16'h0f0f, 16, 5, rx);
      cs_rise();
      check("post_abort_miso_word", {16'h0, rx}, 32'h3c3c);

      // Reset mid-frame with CS held low across release.
      set_mode(SPI_MODE0);
      bus.spi_sdata = 16'hffff;
      cs_fall();
      shift_word(SPI_MODE0, 16'haaab, 5, 5, rx);
      wait_cyc(2);
      sys_rst_n = 1'b0;
      #1;
      check("midrst_miso",  {31'h0, bus.spi_miso},  32'h0);
      check("midrst_rdata", {16'h0, bus.spi_rdata}, 32'h0);
      check("midrst_done",  {31'h0, bus.spi_done},  32'h0);
      check("midrst_busy",  {31'h0, bus.spi_busy},  32'h0);
      check("midrst_abort", {31'h0, bus.spi_abort}, 32'h0);
      wait_cyc(3);
      sys_rst_n = 1'b1;
      wait_cyc(10);
      check("rst_release_cs_low_busy", {31'h0, bus.spi_busy}, 32'h0);
      bus.spi_cs_n = 1'b1;
      wait_cyc(8);
      bus.spi_sdata = 16'h1234;
      exp_q.push_back(16'haaab);
      cs_fall();
      shift_word(SPI_MODE0, 16'haaab, 16, 5, rx);
      cs_rise();
      check("post_rst_miso_word", {16'h0, rx}, 32'h1234);

      // SCLK at sys_clk/8, mode 0, with done latency.
      set_mode(SPI_MODE0);
      bus.spi_sdata = 16'ha5a5;
      exp_q.push_back(16'h5a5a);
      cs_fall();
      shift_word(SPI_MODE0, 16'h5a5a, 16, 4, rx);
      cs_rise();
      check("fast_miso_word", {16'h0, rx}, 32'ha5a5);
      check("fast_done_latency", done_cyc - last_sample_cyc, 3);

      check("exp_q_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave endpoint that pairs with the team's SPI master and its `spi_config` sequencer. It receives `spi_sclk`, `spi_cs_n` and `spi_mosi` from an external master and oversamples them on `sys_clk`. It shifts 16-bit words in and out, MSB first, in any of the four SPI modes. Each completed frame is delivered to user logic on the same `spi_done`/`spi_rdata`/`spi_sdata` style interface the master side uses, so the two ends loop back directly in simulation and on the board.

## Interface
- `DATA_W`, 16, frame length in bits.
- `SYNC_STAGES`, 2, synchronizer depth for `spi_sclk`, `spi_cs_n` and `spi_mosi`.
- `sys_clk`  in  1  system clock, 50 MHz.
- `sys_rst_n`  in  1  one clock; reset is asynchronous and active-low.
- `spi_mode`  in  2  {CPOL, CPHA}; latched at frame start.
- `spi_sclk`  in  1  SPI clock from the master (asynchronous).
- `spi_cs_n`  in  1  chip select, active low (asynchronous).
- `spi_mosi`  in  1  master-out data.
- `spi_miso`  out  1  slave-out data; drives 0 while deselected.
- `spi_sdata`  in  DATA_W  word to return to the master; captured at each load.
- `spi_rdata`  out  DATA_W  last complete received word.
- `spi_done`  out  1  one-cycle pulse when a full word has been received.
- `spi_busy`  out  1  high while selected and the FSM is in SHIFT.
- `spi_abort`  out  1  one-cycle pulse when CS deasserts mid-word.

## Operation
- Each of `spi_sclk`, `spi_cs_n` and `spi_mosi` passes through a SYNC_STAGES flop chain, then one edge-detect register.
- Edge definitions:
  - Leading edge: the synced SCLK leaves the CPOL idle level.
  - Trailing edge: it returns to the CPOL idle level.
  - CPHA=0: sample on the leading edge, drive on the trailing edge.
  - CPHA=1: drive on the leading edge, sample on the trailing edge.
- FSM states: IDLE and SHIFT.
  - IDLE → SHIFT on the synced CS falling edge ("load").
  - SHIFT → IDLE on the synced CS rising edge.
- Load action:
  - `tx_shift <= spi_sdata`, `bit_cnt <= 0`, `tx_hold <= 1`.
  - `spi_mode` is latched into `mode_q`.
  - `spi_miso = tx_shift[DATA_W-1]` from the following cycle.
- Sample edge:
  - `rx_shift <= {rx_shift[DATA_W-2:0], mosi_s}`, `bit_cnt++`.
  - CPHA=0: also clears `tx_hold`.
- Drive edge:
  - If `tx_hold` is set, clear it and do not shift; this applies only to the first CPHA=1 drive edge of a word.
  - Otherwise `tx_shift <<= 1`.
  - CPHA=0: a drive edge arriving while `tx_hold` is set is ignored; this covers the trailing edge of bit 16.
- Word complete (the sample edge that makes `bit_cnt` reach DATA_W):
  - `spi_rdata <= {rx_shift[DATA_W-2:0], mosi_s}`; pulse `spi_done`.
  - `bit_cnt <= 0`; reload `tx_shift` from `spi_sdata` and set `tx_hold`.
  - CS still low: the next word continues back-to-back.
- CS rising while `bit_cnt != 0`:
  - Partial word discarded; `spi_rdata` unchanged; no `spi_done`.
  - `spi_abort` pulses; return to IDLE.
- CS rising while `bit_cnt == 0`: plain return to IDLE, no abort.
- SCLK edges seen in IDLE are ignored.
- `spi_mode` changes are ignored until the next load.

## Timing
- Reset values:
  - Outputs: `spi_miso`=0, `spi_rdata`=0, `spi_done`=0, `spi_busy`=0, `spi_abort`=0.
  - Internal: FSM in IDLE, `bit_cnt`=0.
- Reset asserted mid-frame: state is lost immediately. After release, the block waits in IDLE for a fresh CS falling edge; a CS already low at release does not start a frame.
- Latency:
  - Pin SCLK edge → internal action: SYNC_STAGES+1 `sys_clk` cycles (3 at default).
  - `spi_done` rises 3 cycles after the pin edge of the 16th sample and is high for exactly 1 cycle.
  - `spi_rdata` is valid in the `spi_done` cycle and held until the next `spi_done`.
- Master requirements:
  - SCLK frequency ≤ `sys_clk`/8; each SCLK phase ≥ 4 `sys_clk` cycles.
  - CS fall → first SCLK edge ≥ 4 `sys_clk`.
  - Last SCLK edge → CS rise ≥ 4 `sys_clk`.
- `spi_sdata` must be stable from the cycle of `spi_done` (or of CS fall) through the load cycle; it is sampled in that load cycle.
- `spi_miso` changes 3–4 `sys_clk` after the pin drive edge, which is within the master's half-period setup window.

## Structure
- Shared package `spi_pkg`:
  - `SPI_DATA_W` = 16.
  - Mode constants `SPI_MODE0`..`SPI_MODE3` = 2'd0..2'd3.
  - FSM state encoding `ST_IDLE`, `ST_SHIFT`.
- Sub-module `spi_sync`: parameterised N-stage synchronizer with async active-low reset and a programmable reset value. Instantiated three times: reset value 1 for `spi_cs_n`, CPOL-independent 0 for `spi_sclk`, 0 for `spi_mosi`.
- The top-level `spi_slave` contains the edge detect, FSM, counters and shift registers.

## Test plan
- Mode 3: master sends 16'haaab, `spi_sdata`=16'h1234 → `spi_rdata`=16'haaab with exactly one `spi_done` pulse; master receives 16'h1234.
- Each of modes 0, 1, 2, 3: master sends 16'h8001, `spi_sdata`=16'h7ffe → `spi_rdata`=16'h8001 and master receives 16'h7ffe in every mode.
- CS held low across two frames (16'haaab, then 16'h5554), with `spi_sdata` changed from 16'h1111 to 16'hbeef in the first `spi_done` cycle → two `spi_done` pulses; master receives 16'h1111 then 16'hbeef.
- CS raised after 7 bits of 16'hffff → `spi_abort` pulses, no `spi_done`, `spi_rdata` keeps its prior value; the next full frame of 16'h0f0f is received correctly.
- `sys_rst_n` pulsed low mid-frame → all outputs return to reset values; a new CS frame of 16'haaab completes normally.
- SCLK at exactly `sys_clk`/8 with 16'h5a5a in mode 0 → correct data in both directions and `spi_done` 3 cycles after the last sample edge.
